aes_inv_cipher_iter: RTL and testbench

- Iterative AES inverse cipher (FIPS 197 InvCipher). Decrypts one 128-bit block using one round per clock.
- Receiving end of the encryption path: takes a ciphertext block and returns the plaintext.
- Round keys come from an external expanded-key store. The store is addressed by key_idx and returns round_key combinationally in the same cycle.
- Valid/ready handshakes on input and output. One block in flight.

---
 rtl/aes_inv_cipher_iter.sv | 207 ++++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_iter
// Iterative AES inverse cipher (FIPS 197 InvCipher), one round per clock.
// Takes a ciphertext block and returns the plaintext. Round keys are fetched
// from an external expanded-key store addressed by key_idx, which answers
// combinationally in the same cycle on round_key. One block in flight.
//
// Parameters:
//   NR         number of rounds: 10, 12 or 14 (AES-128/192/256)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   ciphertext block offered
//   in_ready   block can be accepted this cycle
//   in_state   ciphertext, FIPS byte order (bits 127:120 = byte 0)
//   key_idx    round-key index requested from the key store (0..NR)
//   round_key  round key for key_idx, valid in the same cycle
//   out_valid  plaintext available
//   out_ready  consumer accepts the plaintext
//   out_state  plaintext, FIPS byte order
//   busy       high whenever the block is not idle
//
// Optional build macro:
//   AES_INV_BACK_TO_BACK_EN  when defined, a new block can be accepted in the
//                            same cycle the previous result is consumed
//                            (in_ready = out_ready while DONE).
// -----------------------------------------------------------------------------
module aes_inv_cipher_iter #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [3:0] KEY_LAST  = 4'(NR);
    localparam logic [3:0] RND_FIRST = 4'(NR - 1);

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[8 * (255 - int'(b)) +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    state_t        state_reg, state_next;
    logic [3:0]    rnd_reg, rnd_next;
    logic [127:0]  st_reg, st_next;

    logic [127:0]  isr_isb;     // InvSubBytes(InvShiftRows(st))
    logic [127:0]  final_out;   // last round result
    logic [127:0]  round_out;   // full round result

    // Byte n sits at row n%4, column n/4. Row r is rotated right by r, so
    // output byte (r, c) comes from input column (c - r) mod 4.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_isb
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            assign isr_isb[127 - 8*gi -: 8] = inv_sbox(st_reg[127 - 8*SRC -: 8]);
        end
    endgenerate

    assign final_out = isr_isb ^ round_key;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_imc
            logic [7:0] a0, a1, a2, a3;
            assign a0 = final_out[127 - 32*gi      -: 8];
            assign a1 = final_out[127 - 32*gi - 8  -: 8];
            assign a2 = final_out[127 - 32*gi - 16 -: 8];
            assign a3 = final_out[127 - 32*gi - 24 -: 8];
            assign round_out[127 - 32*gi -: 32] = {
                mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)
            };
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rnd_reg   <= 4'd0;
            st_reg    <= '0;
        end else begin
            state_reg <= state_next;
            rnd_reg   <= rnd_next;
            st_reg    <= st_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rnd_next   = rnd_reg;
        st_next    = st_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        key_idx    = KEY_LAST;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_next    = in_state ^ round_key;
                    rnd_next   = RND_FIRST;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                busy     = 1'b1;
                key_idx  = rnd_reg;
                st_next  = round_out;
                rnd_next = rnd_reg - 4'd1;
                if (rnd_reg == 4'd1) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                busy       = 1'b1;
                key_idx    = 4'd0;
                st_next    = final_out;
                state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef AES_INV_BACK_TO_BACK_EN
                // key_idx stays at NR here, so the initial key is on round_key
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        st_next    = in_state ^ round_key;
                        rnd_next   = RND_FIRST;
                        state_next = ROUND;
                    end else begin
                        state_next = IDLE;
                    end
                end
`else
                if (out_ready) begin
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
        // Handshake outputs are forced quiet while reset is held.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
        end
    end

    assign out_state = st_reg;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
// Self-checking bench for aes_inv_cipher_iter. Two instances: AES-256 (NR=14)
// and AES-128 (NR=10). Key stores are modelled as arrays filled by a key
// expansion written from the FIPS 197 algorithm; plaintexts are predicted by
// a byte-level InvCipher model using an S-box derived from GF(2^8) inversion.
// -----------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;

    logic clk;
    logic rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_state, a_round_key, a_out_state;
    logic [3:0]   a_key_idx;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_state, b_round_key, b_out_state;
    logic [3:0]   b_key_idx;

    logic [127:0] ks_a [0:15];
    logic [127:0] ks_b [0:15];
    logic [7:0]   sb  [0:255];
    logic [7:0]   isb [0:255];

    int vectors;
    int miscompares;
    int kseq [$];

    assign a_round_key = ks_a[a_key_idx];
    assign b_round_key = ks_b[b_key_idx];

    aes_inv_cipher_iter #(.NR(14)) dut (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_state(a_in_state),
        .key_idx(a_key_idx), .round_key(a_round_key),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_state(a_out_state),
        .busy(a_busy)
    );

    aes_inv_cipher_iter #(.NR(10)) dut_128 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state),
        .key_idx(b_key_idx), .round_key(b_round_key),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_state(b_out_state),
        .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input int which);
        logic [31:0]  w [0:63];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 16; r++) begin
            rk = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
            if (which == 0) ks_a[r] = rk;
            else            ks_b[r] = rk;
        end
    endtask

    task automatic set_key_a(input logic [255:0] k);
        expand(k, 8, 14, 0);
    endtask

    task automatic set_key_b(input logic [127:0] k);
        expand({k, 128'h0}, 4, 10, 1);
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr, input int which);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k, res;
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8];
        for (int rd = nr; rd >= 0; rd--) begin
            if (rd != nr) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        t[r + 4*c] = isb[s[r + 4*((c - r + 4) % 4)]];
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            k = (which == 0) ? ks_a[rd] : ks_b[rd];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
            if (rd != nr && rd != 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand128(), rand128()};
    endfunction

    // ---------------- driver for the NR=14 instance ----------------
    // Offers ct, waits for acceptance, then runs until out_valid. lat counts
    // clock edges with the accepting edge as 1. Leaves the result in DONE.
    task automatic send_a(input logic [127:0] ct, input logic ready, input bit garbage,
                          output logic [127:0] pt, output int lat, output int rdy_seen,
                          output bit ok);
        int guard;
        kseq.delete();
        ok = 1'b0; lat = 0; rdy_seen = 0; pt = '0;
        a_out_ready = ready;
        a_in_state  = ct;
        a_in_valid  = 1'b1;
        guard = 0;
        while (!a_in_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        if (!a_in_ready) begin
            a_in_valid = 1'b0;
            return;
        end
        kseq.push_back(int'(a_key_idx));
        @(posedge clk); #1;
        lat = 1;
        a_in_valid = 1'b0;
        a_in_state = rand128();
        while (!a_out_valid && lat < 40) begin
            kseq.push_back(int'(a_key_idx));
            if (a_in_ready) rdy_seen++;
            if (garbage) begin
                a_in_valid = 1'($urandom);
                a_in_state = rand128();
            end
            @(posedge clk); #1; lat++;
        end
        a_in_valid = 1'b0;
        if (!a_out_valid) return;
        ok = 1'b1;
        pt = a_out_state;
    endtask

    task automatic consume_a();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_state = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_state = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 0", a_in_ready); end
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
        rst = 1'b0;
        #1;
        vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready: got %b expected 1", a_in_ready); end
        vectors++; if (a_out_state !== 128'h0) begin miscompares++; $display("FAIL idle_out_state: got %h expected 0", a_out_state); end
        vectors++; if (a_key_idx !== 4'd14) begin miscompares++; $display("FAIL idle_key_idx: got %0d expected 14", a_key_idx); end
        vectors++; if (b_key_idx !== 4'd10) begin miscompares++; $display("FAIL idle_key_idx_128: got %0d expected 10", b_key_idx); end
    endtask

    task automatic test_aes256_vector();
        logic [127:0] pt;
        int lat, rdy;
        bit ok;
        set_key_a(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        send_a(128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, 1'b0, pt, lat, rdy, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL aes256_done: got %b expected 1", ok); end
        vectors++; if (pt !== 128'h00112233445566778899aabbccddeeff) begin miscompares++; $display("FAIL aes256_pt: got %h expected 00112233445566778899aabbccddeeff", pt); end
        vectors++; if (lat != 15) begin miscompares++; $display("FAIL aes256_latency: got %0d expected 15", lat); end
        vectors++; if (kseq.size() != 15) begin miscompares++; $display("FAIL aes256_kseq_len: got %0d expected 15", kseq.size()); end
        for (int i = 0; i < kseq.size() && i < 15; i++) begin
            vectors++; if (kseq[i] != 14 - i) begin miscompares++; $display("FAIL aes256_key_idx[%0d]: got %0d expected %0d", i, kseq[i], 14 - i); end
        end
        consume_a();
        vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL aes256_back_idle: got %b expected 1", a_in_ready); end
    endtask

    task automatic test_aes128_vector();
        int lat;
        set_key_b(128'h000102030405060708090a0b0c0d0e0f);
        b_out_ready = 1'b1;
        b_in_state  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        b_in_valid  = 1'b1;
        #1;
        vectors++; if (b_in_ready !== 1'b1) begin miscompares++; $display("FAIL aes128_in_ready: got %b expected 1", b_in_ready); end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        vectors++; if (lat != 11) begin miscompares++; $display("FAIL aes128_latency: got %0d expected 11", lat); end
        vectors++; if (b_out_state !== 128'h00112233445566778899aabbccddeeff) begin miscompares++; $display("FAIL aes128_pt: got %h expected 00112233445566778899aabbccddeeff", b_out_state); end
        @(posedge clk); #1;
        vectors++; if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL aes128_consumed: got %b expected 0", b_out_valid); end
    endtask

    task automatic test_random();
        logic [127:0] ct, pt, exp_pt;
        int lat, rdy;
        bit ok;
        for (int n = 0; n < 6; n++) begin
            set_key_a(rand256());
            ct = rand128();
            exp_pt = ref_decrypt(ct, 14, 0);
            send_a(ct, 1'b1, 1'b0, pt, lat, rdy, ok);
            vectors++; if (pt !== exp_pt || !ok) begin miscompares++; $display("FAIL random_pt[%0d]: got %h expected %h", n, pt, exp_pt); end
            vectors++; if (lat != 15) begin miscompares++; $display("FAIL random_latency[%0d]: got %0d expected 15", n, lat); end
            consume_a();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] ct, pt, exp_pt;
        int lat, rdy;
        bit ok;
        ct = rand128();
        exp_pt = ref_decrypt(ct, 14, 0);
        send_a(ct, 1'b0, 1'b0, pt, lat, rdy, ok);
        vectors++; if (pt !== exp_pt || !ok) begin miscompares++; $display("FAIL bp_pt: got %h expected %h", pt, exp_pt); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (a_out_valid !== 1'b1 || a_out_state !== exp_pt || a_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b state=%h expected valid=1 ready=0 state=%h",
                         c, a_out_valid, a_in_ready, a_out_state, exp_pt);
            end
        end
        consume_a();
        vectors++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got valid=%b ready=%b busy=%b expected 0/1/0", a_out_valid, a_in_ready, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct, pt, exp_pt;
        int lat, rdy;
        bit ok;
        a_out_ready = 1'b1;
        a_in_state  = rand128();
        a_in_valid  = 1'b1;
        @(posedge clk); #1;          // accepting edge, now in ROUND cycle 1
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);   // now in ROUND cycle 5
        #1;
        vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b expected 1", a_busy); end
        rst = 1'b1;
        #1;
        vectors++; if (a_in_ready !== 1'b0 || a_busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_held: got ready=%b busy=%b expected 0/0", a_in_ready, a_busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after_rst: got ready=%b busy=%b valid=%b expected 1/0/0", a_in_ready, a_busy, a_out_valid);
        end
        vectors++; if (a_out_state !== 128'h0) begin miscompares++; $display("FAIL mid_state_clear: got %h expected 0", a_out_state); end
        ct = rand128();
        exp_pt = ref_decrypt(ct, 14, 0);
        send_a(ct, 1'b1, 1'b0, pt, lat, rdy, ok);
        vectors++; if (pt !== exp_pt || !ok) begin miscompares++; $display("FAIL mid_next_pt: got %h expected %h", pt, exp_pt); end
        consume_a();
    endtask

    task automatic test_garbage();
        logic [127:0] ct, pt, exp_pt;
        int lat, rdy;
        bit ok;
        ct = rand128();
        exp_pt = ref_decrypt(ct, 14, 0);
        send_a(ct, 1'b1, 1'b1, pt, lat, rdy, ok);
        vectors++; if (pt !== exp_pt || !ok) begin miscompares++; $display("FAIL garbage_pt: got %h expected %h", pt, exp_pt); end
        vectors++; if (rdy != 0) begin miscompares++; $display("FAIL garbage_in_ready: got %0d ready cycles expected 0", rdy); end
        consume_a();
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct [2];
        logic [127:0] exp_pt [2];
        logic [127:0] got [2];
        int t_done [2];
        int n_acc, n_done, cyc, exp_gap;
        bit acc;
        set_key_a(rand256());
        for (int i = 0; i < 2; i++) begin
            ct[i] = rand128();
            exp_pt[i] = ref_decrypt(ct[i], 14, 0);
            got[i] = '0;
            t_done[i] = 0;
        end
`ifdef AES_INV_BACK_TO_BACK_EN
        exp_gap = 15;   // accept in DONE, 13 ROUND, FINAL
`else
        exp_gap = 16;   // DONE, then accept from IDLE, 13 ROUND, FINAL
`endif
        a_out_ready = 1'b1;
        a_in_state  = ct[0];
        a_in_valid  = 1'b1;
        n_acc = 0; n_done = 0; cyc = 0;
        while (n_done < 2 && cyc < 100) begin
            acc = a_in_valid && a_in_ready;
            if (a_out_valid) begin
                got[n_done] = a_out_state;
                t_done[n_done] = cyc;
                n_done++;
            end
            @(posedge clk); #1; cyc++;
            if (acc) begin
                n_acc++;
                if (n_acc == 1) a_in_state = ct[1];
                else            a_in_valid = 1'b0;
            end
        end
        a_in_valid = 1'b0;
        vectors++; if (n_done != 2) begin miscompares++; $display("FAIL b2b_count: got %0d results expected 2", n_done); end
        vectors++; if (got[0] !== exp_pt[0]) begin miscompares++; $display("FAIL b2b_pt0: got %h expected %h", got[0], exp_pt[0]); end
        vectors++; if (got[1] !== exp_pt[1]) begin miscompares++; $display("FAIL b2b_pt1: got %h expected %h", got[1], exp_pt[1]); end
        vectors++; if (t_done[1] - t_done[0] != exp_gap) begin miscompares++; $display("FAIL b2b_gap: got %0d expected %0d", t_done[1] - t_done[0], exp_gap); end
        @(posedge clk); #1;
        vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle: got %b expected 1", a_in_ready); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        build_sbox();
        for (int r = 0; r < 16; r++) begin
            ks_a[r] = '0;
            ks_b[r] = '0;
        end
        test_reset();
        test_aes256_vector();
        test_aes128_vector();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_garbage();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
